// File: rtl/wb_retire.sv
// In-order retire/writeback stage: retires the longest legal head-of-ROB prefix,
// filters same-register write collisions, commits one store per cycle and holds
// the pipeline in a flush state when an excepting entry reaches the head.
module wb_retire #(
    parameter int unsigned RETIRE_WIDTH = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned CW           = $clog2(RETIRE_WIDTH)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [RETIRE_WIDTH-1:0] slot_valid,
    input  logic [REG_ADDR_W-1:0]   slot_dest_reg   [RETIRE_WIDTH],
    input  logic [RETIRE_WIDTH-1:0] slot_dest_valid,
    input  logic [DATA_WIDTH-1:0]   slot_result_lo  [RETIRE_WIDTH],
    input  logic [DATA_WIDTH-1:0]   slot_result_hi  [RETIRE_WIDTH],
    input  logic [RETIRE_WIDTH-1:0] slot_hilo_valid,
    input  logic [RETIRE_WIDTH-1:0] slot_is_store,
    input  logic [RETIRE_WIDTH-1:0] slot_exception,
    input  logic [31:0]             slot_pc         [RETIRE_WIDTH],
    output logic                    consume,
    output logic [CW-1:0]           consume_count,
    output logic                    store_commit_valid,
    input  logic                    store_commit_ready,
    output logic [REG_ADDR_W-1:0]   rfile_wr_addr   [RETIRE_WIDTH],
    output logic [RETIRE_WIDTH-1:0] rfile_wr_enable,
    output logic [DATA_WIDTH-1:0]   rfile_wr_data   [RETIRE_WIDTH],
    output logic                    hilo_wr_enable,
    output logic [DATA_WIDTH-1:0]   hilo_wr_hi,
    output logic [DATA_WIDTH-1:0]   hilo_wr_lo,
    output logic                    flush_req,
    output logic [31:0]             flush_pc,
    input  logic                    flush_ack,
    output logic [31:0]             retired_total
);

    localparam int unsigned NW = $clog2(RETIRE_WIDTH + 1);

    typedef enum logic {StRun, StFlush} state_e;

    state_e                  state;
    logic [RETIRE_WIDTH-1:0] retire_mask;
    logic [NW-1:0]           n_retire;
    logic                    scan_ok;
    logic                    store_seen;
    logic                    exc_hit;
    logic [31:0]             exc_pc;
    logic [RETIRE_WIDTH-1:0] wr_en_d;
    logic                    hilo_en_d;
    logic [DATA_WIDTH-1:0]   hi_d;
    logic [DATA_WIDTH-1:0]   lo_d;

    // Prefix scan: stop at the first invalid, excepting or un-committable store slot.
    always_comb begin
        retire_mask        = '0;
        n_retire           = '0;
        scan_ok            = 1'b1;
        store_seen         = 1'b0;
        exc_hit            = 1'b0;
        exc_pc             = '0;
        store_commit_valid = 1'b0;
        if (state == StRun) begin
            for (int i = 0; i < int'(RETIRE_WIDTH); i++) begin
                if (scan_ok) begin
                    if (!slot_valid[i]) begin
                        scan_ok = 1'b0;
                    end else if (slot_exception[i]) begin
                        scan_ok = 1'b0;
                        exc_hit = 1'b1;
                        exc_pc  = slot_pc[i];
                    end else if (slot_is_store[i]) begin
                        if (store_seen) begin
                            // Only one store may commit per cycle.
                            scan_ok = 1'b0;
                        end else begin
                            store_seen         = 1'b1;
                            store_commit_valid = 1'b1;
                            if (store_commit_ready) begin
                                retire_mask[i] = 1'b1;
                                n_retire       = n_retire + NW'(1);
                            end else begin
                                scan_ok = 1'b0;
                            end
                        end
                    end else begin
                        retire_mask[i] = 1'b1;
                        n_retire       = n_retire + NW'(1);
                    end
                end
            end
        end
        consume       = (n_retire != '0);
        consume_count = (n_retire == '0) ? '0 : CW'(n_retire - NW'(1));
    end

    // Write-enable filtering: a younger retiring writer to the same GPR wins.
    always_comb begin
        hilo_en_d = 1'b0;
        hi_d      = '0;
        lo_d      = '0;
        for (int i = 0; i < int'(RETIRE_WIDTH); i++) begin
            wr_en_d[i] = retire_mask[i] & slot_dest_valid[i];
            for (int j = i + 1; j < int'(RETIRE_WIDTH); j++) begin
                if (retire_mask[j] && slot_dest_valid[j] && slot_dest_reg[j] == slot_dest_reg[i]) begin
                    wr_en_d[i] = 1'b0;
                end
            end
            if (retire_mask[i] && slot_hilo_valid[i]) begin
                hilo_en_d = 1'b1;
                hi_d      = slot_result_hi[i];
                lo_d      = slot_result_lo[i];
            end
        end
    end

    // Registered register-file / HI-LO writes and the retired instruction counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rfile_wr_enable <= '0;
            for (int i = 0; i < int'(RETIRE_WIDTH); i++) begin
                rfile_wr_addr[i] <= '0;
                rfile_wr_data[i] <= '0;
            end
            hilo_wr_enable <= 1'b0;
            hilo_wr_hi     <= '0;
            hilo_wr_lo     <= '0;
            retired_total  <= '0;
        end else begin
            rfile_wr_enable <= wr_en_d;
            for (int i = 0; i < int'(RETIRE_WIDTH); i++) begin
                if (wr_en_d[i]) begin
                    rfile_wr_addr[i] <= slot_dest_reg[i];
                    rfile_wr_data[i] <= slot_result_lo[i];
                end
            end
            hilo_wr_enable <= hilo_en_d;
            if (hilo_en_d) begin
                hilo_wr_hi <= hi_d;
                hilo_wr_lo <= lo_d;
            end
            retired_total <= retired_total + 32'(n_retire);
        end
    end

    // Flush FSM: enter on an excepting head entry, leave when the front end acks.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= StRun;
            flush_req <= 1'b0;
            flush_pc  <= '0;
        end else begin
            unique case (state)
                StRun: begin
                    if (exc_hit) begin
                        state     <= StFlush;
                        flush_req <= 1'b1;
                        flush_pc  <= exc_pc;
                    end
                end
                StFlush: begin
                    if (flush_ack) begin
                        state     <= StRun;
                        flush_req <= 1'b0;
                    end
                end
                default: state <= StRun;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_retire.sv
// Bench for wb_retire: directed steps from the feature list followed by random
// traffic, all checked against a behavioural model of the retire rules.
module tb_wb_retire;

    localparam int RW = 4;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CWL = 2;

    logic            clock = 1'b0;
    logic            reset_n = 1'b1;
    logic [RW-1:0]   slot_valid;
    logic [AW-1:0]   slot_dest_reg [RW];
    logic [RW-1:0]   slot_dest_valid;
    logic [DW-1:0]   slot_result_lo [RW];
    logic [DW-1:0]   slot_result_hi [RW];
    logic [RW-1:0]   slot_hilo_valid;
    logic [RW-1:0]   slot_is_store;
    logic [RW-1:0]   slot_exception;
    logic [31:0]     slot_pc [RW];
    logic            consume;
    logic [CWL-1:0]  consume_count;
    logic            store_commit_valid;
    logic            store_commit_ready;
    logic [AW-1:0]   rfile_wr_addr [RW];
    logic [RW-1:0]   rfile_wr_enable;
    logic [DW-1:0]   rfile_wr_data [RW];
    logic            hilo_wr_enable;
    logic [DW-1:0]   hilo_wr_hi;
    logic [DW-1:0]   hilo_wr_lo;
    logic            flush_req;
    logic [31:0]     flush_pc;
    logic            flush_ack;
    logic [31:0]     retired_total;

    wb_retire #(
        .RETIRE_WIDTH(RW),
        .DATA_WIDTH  (DW),
        .REG_ADDR_W  (AW),
        .CW          (CWL)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .slot_valid        (slot_valid),
        .slot_dest_reg     (slot_dest_reg),
        .slot_dest_valid   (slot_dest_valid),
        .slot_result_lo    (slot_result_lo),
        .slot_result_hi    (slot_result_hi),
        .slot_hilo_valid   (slot_hilo_valid),
        .slot_is_store     (slot_is_store),
        .slot_exception    (slot_exception),
        .slot_pc           (slot_pc),
        .consume           (consume),
        .consume_count     (consume_count),
        .store_commit_valid(store_commit_valid),
        .store_commit_ready(store_commit_ready),
        .rfile_wr_addr     (rfile_wr_addr),
        .rfile_wr_enable   (rfile_wr_enable),
        .rfile_wr_data     (rfile_wr_data),
        .hilo_wr_enable    (hilo_wr_enable),
        .hilo_wr_hi        (hilo_wr_hi),
        .hilo_wr_lo        (hilo_wr_lo),
        .flush_req         (flush_req),
        .flush_pc          (flush_pc),
        .flush_ack         (flush_ack),
        .retired_total     (retired_total)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit          m_flush;
    logic [31:0] m_pc;
    logic [31:0] m_total;
    logic [RW-1:0] m_en;
    logic [AW-1:0] m_addr [RW];
    logic [DW-1:0] m_data [RW];
    bit          m_hen;
    logic [DW-1:0] m_hi;
    logic [DW-1:0] m_lo;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_flush = 1'b0;
        m_pc    = '0;
        m_total = '0;
        m_en    = '0;
        m_hen   = 1'b0;
        m_hi    = '0;
        m_lo    = '0;
        for (int i = 0; i < RW; i++) begin
            m_addr[i] = '0;
            m_data[i] = '0;
        end
    endtask

    task automatic clear_slots();
        slot_valid      = '0;
        slot_dest_valid = '0;
        slot_hilo_valid = '0;
        slot_is_store   = '0;
        slot_exception  = '0;
        for (int i = 0; i < RW; i++) begin
            slot_dest_reg[i]  = '0;
            slot_result_lo[i] = '0;
            slot_result_hi[i] = '0;
            slot_pc[i]        = '0;
        end
    endtask

    task automatic set_alu(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] val);
        slot_valid[i]      = 1'b1;
        slot_dest_valid[i] = 1'b1;
        slot_dest_reg[i]   = rd;
        slot_result_lo[i]  = val;
        slot_pc[i]         = 32'h0040_0000 + 32'(i * 4);
    endtask

    task automatic set_store(input int i);
        slot_valid[i]    = 1'b1;
        slot_is_store[i] = 1'b1;
        slot_pc[i]       = 32'h0040_0000 + 32'(i * 4);
    endtask

    // Retire rules: walk from the oldest slot, stop at the first invalid slot,
    // exception, store that cannot commit, or second store.
    task automatic model_scan(output int n, output bit scv, output bit exc, output logic [31:0] epc);
        int stores;
        n = 0; scv = 0; exc = 0; epc = '0; stores = 0;
        if (m_flush) return;
        for (int i = 0; i < RW; i++) begin
            if (!slot_valid[i]) break;
            if (slot_exception[i]) begin
                exc = 1; epc = slot_pc[i];
                break;
            end
            if (slot_is_store[i]) begin
                stores++;
                if (stores > 1) break;
                scv = 1;
                if (!store_commit_ready) break;
            end
            n = i + 1;
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".flush_req"}, 64'(flush_req), 64'(m_flush));
        chk({tag, ".flush_pc"}, 64'(flush_pc), 64'(m_pc));
        chk({tag, ".total"}, 64'(retired_total), 64'(m_total));
        chk({tag, ".wr_en"}, 64'(rfile_wr_enable), 64'(m_en));
        for (int i = 0; i < RW; i++) begin
            if (m_en[i]) begin
                chk($sformatf("%s.wr_addr%0d", tag, i), 64'(rfile_wr_addr[i]), 64'(m_addr[i]));
                chk($sformatf("%s.wr_data%0d", tag, i), 64'(rfile_wr_data[i]), 64'(m_data[i]));
            end
        end
        chk({tag, ".hilo_en"}, 64'(hilo_wr_enable), 64'(m_hen));
        if (m_hen) begin
            chk({tag, ".hi"}, 64'(hilo_wr_hi), 64'(m_hi));
            chk({tag, ".lo"}, 64'(hilo_wr_lo), 64'(m_lo));
        end
    endtask

    // One clock: inputs are already applied; check comb outputs at negedge,
    // advance the model, then check registered outputs just after the edge.
    task automatic cycle(input string tag);
        int          n;
        bit          scv;
        bit          exc;
        logic [31:0] epc;
        int          last [32];
        model_scan(n, scv, exc, epc);
        @(negedge clock);
        chk({tag, ".consume"}, 64'(consume), 64'(n > 0));
        chk({tag, ".count"}, 64'(consume_count), 64'((n > 0) ? n - 1 : 0));
        chk({tag, ".store_valid"}, 64'(store_commit_valid), 64'(scv));
        for (int r = 0; r < 32; r++) last[r] = -1;
        for (int i = 0; i < n; i++) if (slot_dest_valid[i]) last[slot_dest_reg[i]] = i;
        m_hen = 1'b0;
        for (int i = 0; i < RW; i++) begin
            m_en[i] = (i < n) && slot_dest_valid[i] && (last[slot_dest_reg[i]] == i);
            if (m_en[i]) begin
                m_addr[i] = slot_dest_reg[i];
                m_data[i] = slot_result_lo[i];
            end
            if (i < n && slot_hilo_valid[i]) begin
                m_hen = 1'b1;
                m_hi  = slot_result_hi[i];
                m_lo  = slot_result_lo[i];
            end
        end
        if (m_flush) begin
            if (flush_ack) m_flush = 1'b0;
        end else if (exc) begin
            m_flush = 1'b1;
            m_pc    = epc;
        end
        m_total = m_total + 32'(n);
        @(posedge clock);
        #1;
        check_regs(tag);
    endtask

    initial begin
        clear_slots();
        store_commit_ready = 1'b0;
        flush_ack          = 1'b0;
        model_reset();
        #1 reset_n = 1'b0;
        #1 check_regs("reset");
        @(posedge clock);
        #1 reset_n = 1'b1;

        cycle("idle");

        // Four ALU results r1..r4
        for (int i = 0; i < RW; i++) set_alu(i, AW'(i + 1), 32'(8'h11 * (i + 1)));
        cycle("four_alu");
        cycle("four_alu2");

        // Hole at slot 2
        clear_slots();
        set_alu(0, 5'd7, 32'h70);
        set_alu(1, 5'd8, 32'h80);
        set_alu(3, 5'd9, 32'h90);
        cycle("hole");

        // Same destination at slots 0 and 2, plus HI/LO writer
        clear_slots();
        set_alu(0, 5'd5, 32'hA);
        set_alu(1, 5'd6, 32'hC);
        set_alu(2, 5'd5, 32'hB);
        slot_hilo_valid[1] = 1'b1;
        slot_result_hi[1]  = 32'hDEAD_BEEF;
        cycle("collide");

        // Store waiting on ready, then store pair
        clear_slots();
        store_commit_ready = 1'b0;
        set_alu(0, 5'd1, 32'h1);
        set_store(1);
        set_alu(2, 5'd2, 32'h2);
        set_alu(3, 5'd3, 32'h3);
        cycle("store_wait");
        clear_slots();
        store_commit_ready = 1'b1;
        set_store(0);
        set_alu(1, 5'd2, 32'h2);
        set_alu(2, 5'd3, 32'h3);
        set_store(3);
        cycle("store_pair");
        store_commit_ready = 1'b0;

        // Exception at slot 2
        clear_slots();
        set_alu(0, 5'd10, 32'h100);
        set_alu(1, 5'd11, 32'h110);
        set_alu(2, 5'd12, 32'h120);
        slot_exception[2] = 1'b1;
        slot_pc[2]        = 32'h0040_0100;
        set_alu(3, 5'd13, 32'h130);
        cycle("exc");
        cycle("flush_hold1");
        cycle("flush_hold2");
        flush_ack = 1'b1;
        cycle("flush_ack");
        flush_ack = 1'b0;
        clear_slots();
        for (int i = 0; i < RW; i++) set_alu(i, AW'(20 + i), 32'(i + 5));
        cycle("after_flush");
        flush_ack = 1'b1;
        cycle("ack_in_run");
        flush_ack = 1'b0;

        // Exception at slot 0, then reset while flushing
        clear_slots();
        set_alu(0, 5'd4, 32'h44);
        slot_exception[0] = 1'b1;
        slot_pc[0]        = 32'h0000_BEE0;
        cycle("exc_slot0");
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_regs("reset_in_flush");
        @(posedge clock);
        #1 reset_n = 1'b1;
        clear_slots();
        cycle("post_reset");

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            clear_slots();
            for (int i = 0; i < RW; i++) begin
                slot_valid[i]      = ($urandom_range(0, 3) != 0);
                slot_is_store[i]   = ($urandom_range(0, 5) == 0);
                slot_exception[i]  = ($urandom_range(0, 15) == 0);
                slot_dest_reg[i]   = AW'($urandom_range(0, 7));
                slot_dest_valid[i] = ($urandom_range(0, 3) != 0);
                slot_hilo_valid[i] = ($urandom_range(0, 2) == 0);
                slot_result_lo[i]  = $urandom;
                slot_result_hi[i]  = $urandom;
                slot_pc[i]         = $urandom;
            end
            store_commit_ready = ($urandom_range(0, 1) != 0);
            flush_ack          = ($urandom_range(0, 2) == 0);
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
